// File: rtl/serial_word_feeder_if.sv
// Word handshake between a parallel producer and serial_word_feeder.
// The master drives the word and direction; the slave answers with din_ready.
interface serial_word_feeder_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             din_dir;
  logic             din_valid;
  logic             din_ready;

  modport master (output din, output din_dir, output din_valid, input din_ready);
  modport slave  (input din, input din_dir, input din_valid, output din_ready);
endinterface

// File: rtl/serial_word_feeder.sv
// Serializes parallel words into a WIDTH-deep bidirectional shift register, one bit per clk.
// Optional WORD_COUNT_EN adds a saturating 8-bit count of completed frames (word_count).
module serial_word_feeder #(
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  serial_word_feeder_if.slave        s_if,
  output logic                       ser_out,
  output logic                       left_out,
  output logic                       busy,
  output logic                       frame_valid
`ifdef WORD_COUNT_EN
  ,
  output logic [7:0]                 word_count
`endif
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic             r_left;
  logic             r_frame;

  logic             w_last;
  logic             w_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_order;

  // MSB-first words are read through a bit-reversed view so cnt always indexes bit 0 first.
  function automatic logic [WIDTH-1:0] reverse_bits(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = v[WIDTH-1-i];
    end
    return r;
  endfunction

  assign w_last   = (r_state == SHIFT) && (r_cnt == LAST);
  assign w_ready  = rst_n & ((r_state == IDLE) | w_last);
  assign w_accept = s_if.din_valid & w_ready;
  assign w_order  = r_left ? reverse_bits(r_shreg) : r_shreg;

  assign s_if.din_ready = w_ready;
  assign ser_out        = (r_state == SHIFT) ? w_order[r_cnt] : 1'b0;
  assign left_out       = r_left;
  assign busy           = (r_state == SHIFT);
  assign frame_valid    = r_frame;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_left  <= 1'b1;
      r_frame <= 1'b0;
    end else begin
      // The last bit enters the downstream register on this edge.
      r_frame <= w_last;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shreg <= s_if.din;
            r_left  <= s_if.din_dir;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_last) begin
            r_cnt <= '0;
            if (w_accept) begin
              r_shreg <= s_if.din;
              r_left  <= s_if.din_dir;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef WORD_COUNT_EN
  logic [7:0] r_word_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_count <= 8'd0;
    end else if (r_frame && (r_word_count != 8'hFF)) begin
      r_word_count <= r_word_count + 8'd1;
    end
  end

  assign word_count = r_word_count;
`endif

endmodule
